// File: rtl/conv_out_packer.sv
// conv_out_packer: receives the convolution pipeline's fixed-latency result
// stream (no backpressure), tags each result with its output-image row/frame
// position and buffers it in a small FIFO. The FIFO drains on a valid/ready
// stream, so a stalling writer cannot disturb the pipeline.
module conv_out_packer #(
    parameter int DATA_W     = 16,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_frame_end,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int OUT_W = IMG_W - 1;
    localparam int OUT_H = IMG_H - 1;
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 2;

    // Each entry is {data, last, frame_end}.
    logic [ENT_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic             busy_reg;
    logic             frame_done_reg;
    logic             overflow_reg;

    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             drop;
    logic             col_last;
    logic             row_last;
    logic             frame_start;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] wr_entry;

    assign full        = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty       = (count_reg == '0);
    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign pop         = !empty && m_ready;
    assign push        = in_valid && (!full || pop);
    assign drop        = in_valid && full && !pop;
    assign col_last    = (col_reg == COL_W'(OUT_W - 1));
    assign row_last    = (row_reg == ROW_W'(OUT_H - 1));
    assign frame_start = in_valid && (col_reg == '0) && (row_reg == '0);
    assign wr_entry    = {in_data, col_last, col_last && row_last};
    assign head        = mem_reg[rd_ptr_reg];

    assign m_valid     = !empty;
    assign m_data      = head[ENT_W-1:2];
    assign m_last      = head[1];
    assign m_frame_end = head[0];
    assign busy        = busy_reg;
    assign frame_done  = frame_done_reg;
    assign overflow    = overflow_reg;

    // FIFO storage: cleared on reset so no stale result is ever presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Output position counters advance on every result, dropped or not,
    // so row/frame alignment survives an overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (in_valid) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_last ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // Frame status: busy from first sample until the frame_end entry leaves;
    // a new frame starting on that same edge keeps busy high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            frame_done_reg <= pop && head[0];
            overflow_reg   <= overflow_reg | drop;
            if (frame_start) begin
                busy_reg <= 1'b1;
            end else if (pop && head[0]) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_out_packer.sv
// Bench for conv_out_packer with a 4x3 input image (3x2 output frame) and a
// 4-entry FIFO. A queue-based model tracks what downstream must see; every
// cycle the DUT outputs are compared with it, and directed literal checks
// pin the model on the documented scenarios.
module tb_conv_out_packer;

    localparam int DATA_W = 16;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int DEPTH  = 4;
    localparam int OUT_W  = IMG_W - 1;
    localparam int FRAME  = (IMG_W - 1) * (IMG_H - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_frame_end;
    logic              busy;
    logic              frame_done;
    logic              overflow;

    int checks = 0;
    int failures = 0;

    conv_out_packer #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_frame_end(m_frame_end), .busy(busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model state: queue of entries downstream still has to receive,
    // sample index within the frame, and the three status flags.
    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
        logic              fe;
    } ent_t;

    ent_t q[$];
    int   pos = 0;
    logic mdl_busy = 1'b0;
    logic mdl_fd = 1'b0;
    logic mdl_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("m_data", 32'(m_data), 32'(q[0].d));
            chk("m_last", 32'(m_last), 32'(q[0].l));
            chk("m_frame_end", 32'(m_frame_end), 32'(q[0].fe));
        end
        chk("busy", 32'(busy), 32'(mdl_busy));
        chk("frame_done", 32'(frame_done), 32'(mdl_fd));
        chk("overflow", 32'(overflow), 32'(mdl_ovf));
    endtask

    // One clock cycle: check, drive, advance model, then let the edge happen.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
        logic pop_m;
        logic pop_fe;
        ent_t e;
        @(negedge clk);
        check_outputs();
        in_valid = v;
        in_data  = d;
        m_ready  = r;
        pop_m  = (q.size() > 0) && r;
        pop_fe = pop_m && q[0].fe;
        if (pop_m) begin
            $display("pop data=%0d last=%0d frame_end=%0d", q[0].d, q[0].l, q[0].fe);
            void'(q.pop_front());
        end
        if (v) begin
            e.d  = d;
            e.l  = ((pos % OUT_W) == OUT_W - 1);
            e.fe = (pos == FRAME - 1);
            if (pos == 0) mdl_busy = 1'b1;
            else if (pop_fe) mdl_busy = 1'b0;
            if (q.size() < DEPTH) q.push_back(e);
            else mdl_ovf = 1'b1;
            pos = (pos + 1) % FRAME;
        end else if (pop_fe) begin
            mdl_busy = 1'b0;
        end
        mdl_fd = pop_fe;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        in_valid = 1'b0;
        m_ready  = 1'b0;
        rst      = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_m_frame_end", 32'(m_frame_end), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        q.delete();
        pos = 0;
        mdl_busy = 1'b0;
        mdl_fd = 1'b0;
        mdl_ovf = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        apply_reset();

        // Six results with downstream always ready.
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, DATA_W'(k), 1'b1);
            chk("a_data", 32'(m_data), k);
            chk("a_last", 32'(m_last), 32'((k == 3) || (k == 6)));
        end
        step(1'b0, '0, 1'b1);
        chk("a_frame_done", 32'(frame_done), 1);
        chk("a_busy_low", 32'(busy), 0);
        step(1'b0, '0, 1'b1);

        // Same stream with downstream stalled: 5 and 6 are dropped.
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, DATA_W'(k), 1'b0);
            if (k == 4) chk("b_ovf_before", 32'(overflow), 0);
            if (k == 5) chk("b_ovf_after", 32'(overflow), 1);
        end
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                chk("b_head4", 32'(m_data), 4);
                chk("b_head4_last", 32'(m_last), 0);
            end
            step(1'b0, '0, 1'b1);
        end
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, DATA_W'(16 + k), 1'b1);
            if (k == 1) chk("b_next_col0", 32'(m_last), 0);
            if (k == 3) chk("b_next_last", 32'(m_last), 1);
        end
        step(1'b0, '0, 1'b1);
        apply_reset();

        // Full FIFO with simultaneous push and pop.
        for (int k = 1; k <= 4; k++) step(1'b1, DATA_W'(k), 1'b0);
        step(1'b1, 16'h55, 1'b1);
        chk("c_no_overflow", 32'(overflow), 0);
        for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1);

        // Ready toggling during a frame.
        for (int k = 1; k <= 6; k++) step(1'b1, DATA_W'(32 + k), k[0]);
        for (int k = 0; k < 8; k++) step(1'b0, '0, k[0]);
        for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1);

        // Reset mid-frame, then a fresh frame.
        for (int k = 1; k <= 3; k++) step(1'b1, DATA_W'(100 + k), 1'b0);
        apply_reset();
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, DATA_W'(200 + k), 1'b1);
            chk("d_data", 32'(m_data), 200 + k);
            chk("d_last", 32'(m_last), 32'((k == 3) || (k == 6)));
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Back-to-back frames.
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, DATA_W'(300 + k), 1'b1);
            if (k == 7) begin
                chk("e_fd7", 32'(frame_done), 1);
                chk("e_busy7", 32'(busy), 1);
            end
        end
        step(1'b0, '0, 1'b1);
        chk("e_fd13", 32'(frame_done), 1);
        chk("e_busy13", 32'(busy), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_out_packer.md
# conv_out_packer

Consumer-side endpoint for the convolution pipeline's delayed valid stream. It accepts one result per cycle flagged by `in_valid`, with no backpressure toward the pipeline, and tracks the output-image position of each result. For a 2×2 kernel the output image is (IMG_W−1)×(IMG_H−1). Results are buffered in a small FIFO and re-emitted on a valid/ready stream with row and frame markers, so a downstream writer can stall without disturbing the fixed-latency datapath.

## Interface
Parameters:
- DATA_W, 16, width of one convolution result
- IMG_W, 8, input image width in pixels (≥2); OUT_W = IMG_W−1
- IMG_H, 8, input image height in pixels (≥2); OUT_H = IMG_H−1
- FIFO_DEPTH, 4, buffer entries, power of two, ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  result strobe from the delayed-valid path
- in_data  in  DATA_W  result, sampled when in_valid=1
- m_valid  out  1  head entry available
- m_ready  in  1  downstream accepts head
- m_data  out  DATA_W  head result
- m_last  out  1  head is last column of an output row
- m_frame_end  out  1  head is last sample of the frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the frame's last sample is popped
- overflow  out  1  sticky: a result was dropped on a full FIFO

## Operation
- Position counters `col` (0..OUT_W−1) and `row` (0..OUT_H−1) advance on every in_valid cycle, including dropped ones, so alignment survives an overflow.
  - When col = OUT_W−1, col wraps to 0 and row increments.
  - At (OUT_W−1, OUT_H−1), both wrap to 0.
- Each written entry stores {in_data, last, frame_end}:
  - last = (col = OUT_W−1)
  - frame_end = last && (row = OUT_H−1)
- Push occurs when in_valid && (!full || pop). Simultaneous push and pop on a full FIFO is legal and leaves the count unchanged.
- Drop occurs when in_valid && full && !pop. The entry is discarded, overflow is set to 1 and held until reset, and the counters still advance.
- Pop occurs when m_valid && m_ready. m_valid = !empty.
  - m_data, m_last and m_frame_end reflect the head entry.
  - These outputs are stable while m_valid && !m_ready.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an occupancy count of log2(FIFO_DEPTH)+1 bits.
- busy:
  - Set on the first in_valid while col=0 and row=0 and busy=0.
  - Cleared in the cycle frame_done is asserted.
  - If a new frame's first sample arrives in that same cycle, busy stays 1.
- frame_done is registered. It pulses high for exactly one cycle, in the cycle after a pop of an entry with frame_end=1.
- Reset (asynchronous assert, any time, including mid-frame):
  - FIFO is emptied and contents discarded; col and row return to 0.
  - m_valid, m_data, m_last, m_frame_end, busy, frame_done and overflow are all 0.
  - Deassertion is used synchronously to clk.

## Timing
- Write latency: in_valid at edge N gives m_valid=1 after edge N, i.e. the data is visible to downstream in cycle N+1. There is no combinational path from in_valid to m_valid.
- Pop latency: m_ready sampled at edge N advances the head after edge N. The new head, or m_valid=0 if empty, is visible in cycle N+1.
- With m_ready held at 1, throughput is 1 result/cycle with zero drops; occupancy never exceeds 1.
- m_ready is used combinationally only for pop and simultaneous-push qualification. It never drives m_valid combinationally.
- overflow rises in the cycle after the dropping edge.

## Test plan
- IMG_W=4, IMG_H=3, m_ready=1, six consecutive in_valid with data 1..6:
  - m_data = 1..6 on cycles 1..6.
  - m_last=1 on data 3 and 6; m_frame_end=1 only on data 6.
  - frame_done pulses on cycle 7; busy is high cycles 1..6 and low on cycle 7.
- Same stream with m_ready=0, FIFO_DEPTH=4:
  - Data 1..4 are buffered; data 5 and 6 are dropped.
  - overflow=1 from cycle 6.
  - After m_ready=1, pops are 1,2,3,4 with no m_last on 4.
  - The next frame's first sample is flagged col 0 (correct alignment).
- Full FIFO with m_ready=1 and in_valid=1 in the same cycle: occupancy stays 4, no drop, overflow stays 0.
- m_ready toggled 1,0,1,0 during a frame: m_data is held constant while stalled, all 6 values arrive in order, no duplicates.
- Reset asserted after 3 samples of a frame, then a fresh 6-sample frame: all outputs read 0 during reset, the old data never appears, and the new frame's m_last falls on its 3rd and 6th samples.
- Back-to-back frames (12 consecutive in_valid, m_ready=1): frame_done pulses on cycles 7 and 13, and busy remains 1 across the frame boundary.
